shift_tx: RTL

SHIFT_TX -- requirements
Module: shift_tx

---
 rtl/shift_tx_pkg.sv | 15 +
 rtl/shift_tx_if.sv | 36 +++
 rtl/shift_tx_shift_reg_dir.sv | 45 ++++
 rtl/shift_tx.sv | 106 ++++++++++
 4 files changed

// File: rtl/shift_tx_pkg.sv
// rtl/shift_tx_pkg.sv - shared state encoding and direction constants for shift_tx
// Purpose: one place for the FSM state type and the shift-direction encoding
//          used by the top-level control and the shift register.
package shift_tx_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEND   = 2'd1,
    FINISH = 2'd2
  } state_t;

  localparam logic DIR_LSB = 1'b0;
  localparam logic DIR_MSB = 1'b1;

endpackage

// File: rtl/shift_tx_if.sv
// rtl/shift_tx_if.sv - word handshake, bit-rate enable and serial line bundle for shift_tx
// Purpose: groups the upstream word handshake, bit-rate enable and line outputs.
// Ports (signals):
//   in_valid/in_ready  word handshake (upstream -> shift_tx)
//   in_data[2**N]      word to serialize
//   in_dir             0 = LSB first, 1 = MSB first
//   in_len[N+1]        bits to send (0 or >2**N means 2**N)
//   bit_tick           one-cycle bit-rate enable
//   ser_out            serial line, idles high
//   frame              high while a word is on the line
//   done               one-cycle pulse after the last bit period
interface shift_tx_if #(
  parameter int N = 3
) ();

  logic                in_valid;
  logic                in_ready;
  logic [(1<<N)-1:0]   in_data;
  logic                in_dir;
  logic [N:0]          in_len;
  logic                bit_tick;
  logic                ser_out;
  logic                frame;
  logic                done;

  modport master (
    output in_valid, in_data, in_dir, in_len, bit_tick,
    input  in_ready, ser_out, frame, done
  );

  modport slave (
    input  in_valid, in_data, in_dir, in_len, bit_tick,
    output in_ready, ser_out, frame, done
  );

endinterface

// File: rtl/shift_tx_shift_reg_dir.sv
// rtl/shift_tx_shift_reg_dir.sv - loadable bidirectional shift register with enable
// Purpose: W-bit register; load has priority over shift; each enable moves the
//          contents one place (right for DIR_LSB, left for DIR_MSB), zero fill.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset (clears register)
//   i_load         load i_load_data this cycle
//   i_load_data    parallel load value
//   i_en           shift one place this cycle
//   i_dir          shift direction (DIR_LSB / DIR_MSB)
//   o_lsb, o_msb   the two end bits, which are the only taps the serializer needs
module shift_reg_dir
  import shift_tx_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_data,
  input  logic         i_en,
  input  logic         i_dir,
  output logic         o_lsb,
  output logic         o_msb
);

  logic [W-1:0] r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_load_data;
    end else if (i_en) begin
      if (i_dir == DIR_MSB) begin
        r_q <= {r_q[W-2:0], 1'b0};
      end else begin
        r_q <= {1'b0, r_q[W-1:1]};
      end
    end
  end

  assign o_lsb = r_q[0];
  assign o_msb = r_q[W-1];

endmodule

// File: rtl/shift_tx.sv
// rtl/shift_tx.sv - parallel-to-serial transmitter with selectable bit order and length
// Purpose: accepts a 2**N-bit word, then sends in_len bits on ser_out, one bit
//          per bit_tick period, followed by a one-cycle done pulse.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   tx             shift_tx_if slave modport (handshake, bit_tick, line outputs)
module shift_tx
  import shift_tx_pkg::*;
#(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  shift_tx_if.slave    tx
);

  localparam int         W       = 1 << N;
  localparam logic [N:0] LEN_MAX = {1'b1, {N{1'b0}}};
  localparam logic [N:0] LEN_ONE = {{N{1'b0}}, 1'b1};

  state_t     r_state;
  state_t     w_next;
  logic       r_dir;
  logic [N:0] r_cnt;
  logic [N:0] w_len;
  logic       w_accept;
  logic       w_shift;
  logic       w_lsb;
  logic       w_msb;

  // Out-of-range lengths (0 or above the word width) send the full word.
  always_comb begin
    w_len = tx.in_len;
    if (tx.in_len == '0 || tx.in_len > LEN_MAX) begin
      w_len = LEN_MAX;
    end
  end

  shift_reg_dir #(
    .W (W)
  ) u_shift_reg (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_load      (w_accept),
    .i_load_data (tx.in_data),
    .i_en        (w_shift),
    .i_dir       (r_dir),
    .o_lsb       (w_lsb),
    .o_msb       (w_msb)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_dir   <= DIR_LSB;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_dir <= tx.in_dir;
        r_cnt <= w_len;
      end else if (w_shift) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  // ser_out depends only on registered state, so the line never glitches
  // with upstream data or direction changes.
  always_comb begin
    w_next      = r_state;
    w_accept    = 1'b0;
    w_shift     = 1'b0;
    tx.in_ready = 1'b0;
    tx.ser_out  = 1'b1;
    tx.frame    = 1'b0;
    tx.done     = 1'b0;
    case (r_state)
      IDLE: begin
        tx.in_ready = 1'b1;
        if (tx.in_valid) begin
          w_accept = 1'b1;
          w_next   = SEND;
        end
      end
      SEND: begin
        tx.frame   = 1'b1;
        tx.ser_out = (r_dir == DIR_MSB) ? w_msb : w_lsb;
        if (tx.bit_tick) begin
          w_shift = 1'b1;
          if (r_cnt == LEN_ONE) begin
            w_next = FINISH;
          end
        end
      end
      FINISH: begin
        tx.done = 1'b1;
        w_next  = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

endmodule
